// File: rtl/resource_credit_sched_pkg.sv
// Shared types and helpers for the credit-based resource scheduler.
package resource_sched_pkg;

    typedef enum logic {
        IDLE,
        LOCK
    } sched_state_t;

    // Width of a requester index; never zero so single-bit fields stay legal.
    function automatic int unsigned idx_bits(input int unsigned num_in);
        return (num_in > 1) ? $clog2(num_in) : 1;
    endfunction

endpackage

// File: rtl/resource_credit_sched_if.sv
// AXI-stream style bundle shared by requesters, resource and result returns.
interface if_axi_stream #(
    parameter int unsigned DAT_BYTS = 8,
    parameter int unsigned CTL_BITS = 16
);
    localparam int unsigned DAT_BITS = DAT_BYTS * 8;
    localparam int unsigned MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

    logic [DAT_BITS-1:0] dat;
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [MOD_BITS-1:0] mod;
    logic [CTL_BITS-1:0] ctl;

    modport source (output dat, val, sop, eop, err, mod, ctl, input rdy);
    modport sink   (input dat, val, sop, eop, err, mod, ctl, output rdy);

endinterface

// File: rtl/resource_credit_sched_rr_pick.sv
// Combinational round-robin pick: first eligible index at or after ptr, with wrap.
module rr_pick
    import resource_sched_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_bits(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] idx,
    output logic          any_elig
);

    logic [IW-1:0] pos;

    // Scan upward from ptr; the first hit wins.
    always_comb begin
        gnt_oh   = '0;
        idx      = '0;
        any_elig = 1'b0;
        pos      = '0;
        for (int i = 0; i < N; i++) begin
            pos = IW'((32'(ptr) + 32'(i)) % N);
            if (!any_elig && elig[pos]) begin
                any_elig    = 1'b1;
                idx         = pos;
                gnt_oh[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/resource_credit_sched.sv
// Packet-granular round-robin scheduler sharing one pipelined resource between
// NUM_IN requesters, with per-requester credit limits on packets in flight.
module resource_credit_sched
    import resource_sched_pkg::*;
#(
    parameter int unsigned NUM_IN      = 4,
    parameter int unsigned DAT_BYTS    = 8,
    parameter int unsigned DAT_BITS    = DAT_BYTS * 8,
    parameter int unsigned CTL_BITS    = 16,
    parameter int unsigned OVR_WRT_BIT = 0,
    parameter int unsigned MAX_CREDIT  = 4,
    localparam int unsigned CNT_BITS   = $clog2(MAX_CREDIT + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    if_axi_stream.sink                 i_axi [NUM_IN],
    if_axi_stream.source               o_res,
    if_axi_stream.sink                 i_res,
    if_axi_stream.source               o_axi [NUM_IN],
    output logic [NUM_IN*CNT_BITS-1:0] o_credit,
    output logic                       o_err
);

    localparam int unsigned IDX_BITS = idx_bits(NUM_IN);
    localparam int unsigned MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

    // Flattened requester inputs
    logic [NUM_IN-1:0]   in_val, in_sop, in_eop, in_err, in_rdy;
    logic [DAT_BITS-1:0] in_dat [NUM_IN];
    logic [MOD_BITS-1:0] in_mod [NUM_IN];
    logic [CTL_BITS-1:0] in_ctl [NUM_IN];

    // Scheduler state
    sched_state_t        state_q, state_d;
    logic [IDX_BITS-1:0] gnt_q, gnt_d;
    logic [IDX_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_BITS-1:0] cnt_q [NUM_IN];
    logic [CNT_BITS-1:0] cnt_d [NUM_IN];
    logic                err_q, err_d;

    // Output register towards the resource
    logic                res_val_q;
    logic [DAT_BITS-1:0] res_dat_q;
    logic                res_sop_q, res_eop_q, res_err_q;
    logic [MOD_BITS-1:0] res_mod_q;
    logic [CTL_BITS-1:0] res_ctl_q;

    // Arbitration / select
    logic [NUM_IN-1:0]   elig, pick_oh, sel_oh, inc;
    logic [IDX_BITS-1:0] pick_idx, sel_idx;
    logic                pick_any, can_acc, xfer;
    logic [DAT_BITS-1:0] sel_dat;
    logic                sel_sop, sel_eop, sel_err;
    logic [MOD_BITS-1:0] sel_mod;
    logic [CTL_BITS-1:0] sel_ctl;

    // Return path
    logic [IDX_BITS-1:0] ret_idx;
    logic                ret_ok, ret_rdy;
    logic [CTL_BITS-1:0] ret_ctl;
    logic [NUM_IN-1:0]   out_val, out_rdy, dec;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_port
        assign in_val[k]      = i_axi[k].val;
        assign in_sop[k]      = i_axi[k].sop;
        assign in_eop[k]      = i_axi[k].eop;
        assign in_err[k]      = i_axi[k].err;
        assign in_dat[k]      = i_axi[k].dat;
        assign in_mod[k]      = i_axi[k].mod;
        assign in_ctl[k]      = i_axi[k].ctl;
        assign i_axi[k].rdy   = in_rdy[k];

        assign o_axi[k].val   = out_val[k];
        assign o_axi[k].dat   = i_res.dat;
        assign o_axi[k].sop   = i_res.sop;
        assign o_axi[k].eop   = i_res.eop;
        assign o_axi[k].err   = i_res.err;
        assign o_axi[k].mod   = i_res.mod;
        assign o_axi[k].ctl   = ret_ctl;
        assign out_rdy[k]     = o_axi[k].rdy;

        assign o_credit[k*CNT_BITS +: CNT_BITS] = cnt_q[k];
    end

    assign o_res.val = res_val_q;
    assign o_res.dat = res_dat_q;
    assign o_res.sop = res_sop_q;
    assign o_res.eop = res_eop_q;
    assign o_res.err = res_err_q;
    assign o_res.mod = res_mod_q;
    assign o_res.ctl = res_ctl_q;
    assign i_res.rdy = ret_rdy;
    assign o_err     = err_q;

    // Eligibility uses registered credit counts only.
    always_comb begin
        elig = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            elig[k] = in_val[k] && in_sop[k] && (32'(cnt_q[k]) < MAX_CREDIT);
        end
    end

    rr_pick #(
        .N  (NUM_IN),
        .IW (IDX_BITS)
    ) u_rr_pick (
        .elig     (elig),
        .ptr      (rr_ptr_q),
        .gnt_oh   (pick_oh),
        .idx      (pick_idx),
        .any_elig (pick_any)
    );

    // Grant select: locked requester, else the round-robin winner of this cycle.
    always_comb begin
        can_acc = !res_val_q || o_res.rdy;
        sel_oh  = '0;
        if (state_q == LOCK) begin
            sel_idx         = gnt_q;
            sel_oh[gnt_q]   = 1'b1;
        end else begin
            sel_idx = pick_idx;
            sel_oh  = pick_any ? pick_oh : '0;
        end
        in_rdy  = can_acc ? sel_oh : '0;
        xfer    = |(in_rdy & in_val);
        inc     = in_rdy & in_val & in_sop;
        sel_dat = in_dat[sel_idx];
        sel_sop = in_sop[sel_idx];
        sel_eop = in_eop[sel_idx];
        sel_err = in_err[sel_idx];
        sel_mod = in_mod[sel_idx];
        sel_ctl = in_ctl[sel_idx];
        sel_ctl[OVR_WRT_BIT +: IDX_BITS] = sel_idx;
    end

    // FSM next state: lock onto a packet until its eop beat is accepted.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            if (sel_eop) begin
                state_d  = IDLE;
                rr_ptr_d = (32'(sel_idx) == NUM_IN - 1) ? '0 : sel_idx + 1'b1;
            end else begin
                state_d = LOCK;
                gnt_d   = sel_idx;
            end
        end
    end

    // Return demux: route by stamped index; out-of-range beats are swallowed.
    always_comb begin
        ret_idx = i_res.ctl[OVR_WRT_BIT +: IDX_BITS];
        ret_ok  = 32'(ret_idx) < NUM_IN;
        ret_ctl = i_res.ctl;
        ret_ctl[OVR_WRT_BIT +: IDX_BITS] = '0;
        out_val = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            out_val[k] = i_res.val && ret_ok && (ret_idx == IDX_BITS'(k));
        end
        ret_rdy = ret_ok ? out_rdy[ret_idx] : 1'b1;
        dec     = out_val & out_rdy & {NUM_IN{i_res.eop}};
    end

    // Credit counters and the sticky error flag.
    always_comb begin
        err_d = err_q || (i_res.val && !ret_ok);
        for (int k = 0; k < NUM_IN; k++) begin
            cnt_d[k] = cnt_q[k];
            if (inc[k] && !dec[k]) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end else if (dec[k] && !inc[k] && (cnt_q[k] != '0)) begin
                cnt_d[k] = cnt_q[k] - 1'b1;
            end
            if (dec[k] && (cnt_q[k] == '0)) begin
                err_d = 1'b1;
            end
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            rr_ptr_q  <= '0;
            res_val_q <= 1'b0;
            err_q     <= 1'b0;
            for (int k = 0; k < NUM_IN; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            if (can_acc) begin
                res_val_q <= xfer;
            end
        end
    end

    // Output payload is held until the resource takes it.
    always_ff @(posedge i_clk) begin
        if (xfer) begin
            res_dat_q <= sel_dat;
            res_sop_q <= sel_sop;
            res_eop_q <= sel_eop;
            res_err_q <= sel_err;
            res_mod_q <= sel_mod;
            res_ctl_q <= sel_ctl;
        end
    end

endmodule

// File: tb/tb_resource_credit_sched.sv
// Directed bench for resource_credit_sched: NUM_IN=4, MAX_CREDIT=2.
module tb_resource_credit_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_val, req_sop, req_eop, req_rdy;
    logic [63:0] req_dat [4];
    logic [15:0] req_ctl [4];
    logic        res_rdy;
    logic        ri_val, ri_sop, ri_eop;
    logic [63:0] ri_dat;
    logic [15:0] ri_ctl;
    logic [3:0]  ret_val, ret_rdy;
    logic [15:0] ret_ctl [4];
    logic [63:0] ret_dat [4];
    logic [7:0]  credit;
    logic        err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [3:0]  cr_rdy  [6];
    logic        cr_ret  [6];
    logic [7:0]  cr_cred [6];

    if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(16)) req_if [4] ();
    if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(16)) ret_if [4] ();
    if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(16)) res_o ();
    if_axi_stream #(.DAT_BYTS(8), .CTL_BITS(16)) res_i ();

    for (genvar k = 0; k < 4; k++) begin : g_tb
        assign req_if[k].val = req_val[k];
        assign req_if[k].sop = req_sop[k];
        assign req_if[k].eop = req_eop[k];
        assign req_if[k].err = 1'b0;
        assign req_if[k].mod = '0;
        assign req_if[k].dat = req_dat[k];
        assign req_if[k].ctl = req_ctl[k];
        assign req_rdy[k]    = req_if[k].rdy;
        assign ret_val[k]    = ret_if[k].val;
        assign ret_ctl[k]    = ret_if[k].ctl;
        assign ret_dat[k]    = ret_if[k].dat;
        assign ret_if[k].rdy = ret_rdy[k];
    end

    assign res_o.rdy = res_rdy;
    assign res_i.val = ri_val;
    assign res_i.sop = ri_sop;
    assign res_i.eop = ri_eop;
    assign res_i.err = 1'b0;
    assign res_i.mod = '0;
    assign res_i.dat = ri_dat;
    assign res_i.ctl = ri_ctl;

    resource_credit_sched #(
        .NUM_IN      (4),
        .DAT_BYTS    (8),
        .CTL_BITS    (16),
        .OVR_WRT_BIT (0),
        .MAX_CREDIT  (2)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_axi    (req_if),
        .o_res    (res_o),
        .i_res    (res_i),
        .o_axi    (ret_if),
        .o_credit (credit),
        .o_err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        req_val = '0;
        req_sop = '0;
        req_eop = '0;
        for (int k = 0; k < 4; k++) begin
            req_dat[k] = '0;
            req_ctl[k] = '0;
        end
    endtask

    task automatic ret_beat(input logic v, input logic [15:0] c, input logic [63:0] d,
                            input logic s, input logic e);
        ri_val = v;
        ri_ctl = c;
        ri_dat = d;
        ri_sop = s;
        ri_eop = e;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        cr_rdy  = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h1};
        cr_ret  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        cr_cred = '{8'h00, 8'h01, 8'h04, 8'h05, 8'h08, 8'h09};
        rst     = 1'b1;
        res_rdy = 1'b1;
        ret_rdy = 4'hF;
        ret_beat(1'b0, 16'h0, 64'h0, 1'b0, 1'b0);
        idle_all();
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state
        check("rst_res_val", 64'(res_o.val), 64'h0);
        check("rst_credit", 64'(credit), 64'h0);
        check("rst_err", 64'(err), 64'h0);

        // Basic: requester 2, 3-beat packet, ctl 0xABC0
        req_val[2] = 1'b1; req_sop[2] = 1'b1; req_eop[2] = 1'b0;
        req_dat[2] = 64'h11; req_ctl[2] = 16'hABC0;
        #1;
        check("basic_rdy", 64'(req_rdy), 64'h4);
        cyc();
        check("basic_b1_val", 64'(res_o.val), 64'h1);
        check("basic_b1_dat", res_o.dat, 64'h11);
        check("basic_b1_ctl", 64'(res_o.ctl), 64'hABC2);
        check("basic_cnt_up", 64'(credit), 64'h10);
        req_sop[2] = 1'b0; req_dat[2] = 64'h22;
        cyc();
        check("basic_b2_dat", res_o.dat, 64'h22);
        req_eop[2] = 1'b1; req_dat[2] = 64'h33;
        cyc();
        check("basic_b3_dat", res_o.dat, 64'h33);
        check("basic_b3_eop", 64'(res_o.eop), 64'h1);
        check("basic_b3_ctl", 64'(res_o.ctl), 64'hABC2);
        idle_all();
        cyc();
        check("basic_drain", 64'(res_o.val), 64'h0);
        // Loopback return
        ret_beat(1'b1, 16'hABC2, 64'h11, 1'b1, 1'b0);
        #1;
        check("ret_val", 64'(ret_val), 64'h4);
        check("ret_ctl", 64'(ret_ctl[2]), 64'hABC0);
        check("ret_dat", ret_dat[2], 64'h11);
        check("ret_rdy", 64'(res_i.rdy), 64'h1);
        cyc();
        check("ret_cnt_hold", 64'(credit), 64'h10);
        ret_beat(1'b1, 16'hABC2, 64'h22, 1'b0, 1'b0);
        cyc();
        ret_beat(1'b1, 16'hABC2, 64'h33, 1'b0, 1'b1);
        cyc();
        ret_beat(1'b0, 16'h0, 64'h0, 1'b0, 1'b0);
        check("ret_cnt_down", 64'(credit), 64'h0);

        // Round-robin: all four send 1-beat packets back to back
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req_val[k] = 1'b1; req_sop[k] = 1'b1; req_eop[k] = 1'b1;
            req_dat[k] = 64'(k);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("rr_val", 64'(res_o.val), 64'h1);
            check("rr_ctl", 64'(res_o.ctl), 64'(i % 4));
            check("rr_dat", res_o.dat, 64'(i % 4));
        end
        check("rr_credit_full", 64'(credit), 64'hAA);
        check("rr_no_rdy", 64'(req_rdy), 64'h0);
        cyc();
        check("rr_drain", 64'(res_o.val), 64'h0);
        idle_all();

        // Credit limit: requester 1 returns stalled, requester 0 keeps flowing
        do_reset();
        ret_rdy = 4'b1101;
        req_val[0] = 1'b1; req_sop[0] = 1'b1; req_eop[0] = 1'b1; req_dat[0] = 64'hA0;
        req_val[1] = 1'b1; req_sop[1] = 1'b1; req_eop[1] = 1'b1; req_dat[1] = 64'hB1;
        for (int s = 0; s < 6; s++) begin
            if (cr_ret[s]) ret_beat(1'b1, 16'h0000, 64'hA0, 1'b1, 1'b1);
            else ret_beat(1'b0, 16'h0, 64'h0, 1'b0, 1'b0);
            #1;
            check("cr_rdy", 64'(req_rdy), 64'(cr_rdy[s]));
            check("cr_credit", 64'(credit), 64'(cr_cred[s]));
            cyc();
        end
        // Slot 5 had an sop accept and an eop return on requester 0 together
        check("sim_inc_dec", 64'(credit), 64'h09);
        req_val[0] = 1'b0;
        ret_beat(1'b1, 16'h0001, 64'hB1, 1'b1, 1'b1);
        #1;
        check("cr_starved", 64'(req_rdy), 64'h0);
        check("cr_ret_val", 64'(ret_val), 64'h2);
        check("cr_ret_stall", 64'(res_i.rdy), 64'h0);
        cyc();
        check("cr_hold", 64'(credit), 64'h09);
        ret_rdy = 4'hF;
        #1;
        check("cr_ret_go", 64'(res_i.rdy), 64'h1);
        check("cr_not_yet", 64'(req_rdy), 64'h0);
        cyc();
        ret_beat(1'b0, 16'h0, 64'h0, 1'b0, 1'b0);
        #1;
        check("cr_regrant", 64'(req_rdy), 64'h2);
        cyc();
        check("cr_third_ctl", 64'(res_o.ctl), 64'h0001);
        check("cr_third_dat", res_o.dat, 64'hB1);
        check("cr_third_cnt", 64'(credit), 64'h09);
        idle_all();

        // Error: return for requester 3 with nothing outstanding
        check("err_clear", 64'(err), 64'h0);
        ret_beat(1'b1, 16'h0003, 64'h5, 1'b1, 1'b1);
        #1;
        check("err_ret_val", 64'(ret_val), 64'h8);
        cyc();
        check("err_set", 64'(err), 64'h1);
        check("err_cnt_sat", 64'(credit), 64'h09);
        ret_beat(1'b0, 16'h0, 64'h0, 1'b0, 1'b0);
        cyc();
        check("err_sticky", 64'(err), 64'h1);

        // Reset mid-packet
        req_val[3] = 1'b1; req_sop[3] = 1'b1; req_eop[3] = 1'b0; req_dat[3] = 64'h33;
        cyc();
        check("rm_first", 64'(res_o.ctl), 64'h0003);
        req_sop[3] = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rm_val", 64'(res_o.val), 64'h0);
        check("rm_credit", 64'(credit), 64'h0);
        check("rm_err", 64'(err), 64'h0);
        req_sop[3] = 1'b1; req_eop[3] = 1'b1;
        req_val[2] = 1'b1; req_sop[2] = 1'b1; req_eop[2] = 1'b1; req_dat[2] = 64'h22;
        req_ctl[2] = 16'h0;
        #1;
        check("rm_idle_rdy", 64'(req_rdy), 64'h4);
        cyc();
        check("rm_gnt2", 64'(res_o.ctl), 64'h0002);
        req_val[2] = 1'b0;
        #1;
        check("rm_rdy3", 64'(req_rdy), 64'h8);
        cyc();
        check("rm_gnt3", 64'(res_o.ctl), 64'h0003);
        idle_all();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/resource_credit_sched.md
# resource_credit_sched

Credit-based scheduler that shares one pipelined resource (e.g. a multiplier) between `NUM_IN` AXI-stream requesters. It is packet-granular and round-robin. It stamps the requester index into the control field and returns results to the originating requester. Each requester has at most `MAX_CREDIT` packets in flight, so a stalled consumer cannot fill the resource pipeline and block the other requesters' returns. It sits between requester blocks and the shared resource, in place of an unbounded arbiter/demux pair.

## Interface
Parameters:
- `NUM_IN`, 4, number of requesters (≥2)
- `DAT_BYTS`, 8, stream data bytes
- `DAT_BITS`, `DAT_BYTS*8`, stream data width
- `CTL_BITS`, 16, control field width
- `OVR_WRT_BIT`, 0, LSB of the index field `ctl[OVR_WRT_BIT +: IDX_BITS]`, where `IDX_BITS = $clog2(NUM_IN)`
- `MAX_CREDIT`, 4, maximum outstanding packets per requester (≥1)

Ports (all `if_axi_stream` ports carry `dat, val, rdy, sop, eop, err, mod, ctl`):
- `i_clk`, in, 1, single clock
- `i_rst`, in, 1, **synchronous, active-high reset**
- `i_axi[NUM_IN]`, `if_axi_stream.sink`, requester inputs
- `o_res`, `if_axi_stream.source`, stream to the resource (registered)
- `i_res`, `if_axi_stream.sink`, results from the resource
- `o_axi[NUM_IN]`, `if_axi_stream.source`, per-requester results
- `o_credit`, out, `NUM_IN*$clog2(MAX_CREDIT+1)`, per-requester outstanding count
- `o_err`, out, 1, sticky: a result returned for a requester with zero outstanding

## Operation
- State machine, states `IDLE` and `LOCK`.
  - In `IDLE`, a requester is eligible when `i_axi[k].val && i_axi[k].sop && cnt[k] < MAX_CREDIT`.
  - The winner is the first eligible requester at or after `rr_ptr`, scanning upward with wrap.
  - The winner is selected combinationally. Its first beat transfers into `o_res` in the same cycle if the output register can accept.
  - If that beat is not `eop`, the state goes to `LOCK` with `gnt = winner`.
  - In `LOCK`, only `i_axi[gnt]` is passed. The state returns to `IDLE` on an accepted `eop`.
- `rr_ptr` updates to `(gnt+1) mod NUM_IN` when the `eop` beat of a packet is accepted.
- Output register: accepts a beat when `!o_res.val || o_res.rdy`. `i_axi[k].rdy` is high only for the granted requester (`IDLE` winner, or `gnt` in `LOCK`) and only when the output register can accept.
- Ctl stamping: `o_res.ctl` equals the input ctl with `ctl[OVR_WRT_BIT +: IDX_BITS]` overwritten by the grant index. All other fields pass through unchanged.
- Credits:
  - `cnt[k]` increments when an `sop` beat from requester k is accepted.
  - `cnt[k]` decrements when an `eop` beat is delivered on `o_axi[k]`.
  - A simultaneous increment and decrement on the same k leaves the count unchanged.
  - A decrement when the count is 0 saturates at 0 and sets `o_err`.
- Return path (combinational):
  - `idx = i_res.ctl[OVR_WRT_BIT +: IDX_BITS]`.
  - `o_axi[k].val = i_res.val && idx==k`.
  - `o_axi[k]` carries all `i_res` fields, with the index field zeroed.
  - `i_res.rdy = o_axi[idx].rdy`.
  - An out-of-range `idx` (non-power-of-two `NUM_IN`) drives `i_res.rdy=1`, drops the beat, and sets `o_err`.

## Timing
- Reset (sync, `i_rst=1` at a clock edge) yields:
  - `o_res.val=0`
  - state `IDLE`
  - `rr_ptr=0`
  - all `cnt=0`
  - `o_err=0`
- Reset mid-packet discards the held beat and the lock. Downstream must also be reset.
- Request-to-`o_res` latency: 1 cycle. Throughput: 1 beat per cycle, with no bubble between back-to-back packets, including across a requester switch.
- Return path latency: 0 cycles (combinational).
- Credit check uses the registered `cnt` only. A credit freed in cycle N makes the requester eligible in cycle N+1.
- A requester with `val` high but no credit never receives `rdy` and does not block other requesters.
- `val` must not depend on `rdy`. Once asserted, `o_res.val` and its data are held until `o_res.rdy`.

## Structure
- Shared package `resource_sched_pkg`:
  - `typedef enum logic {IDLE, LOCK} sched_state_t`
  - function `idx_bits(NUM_IN)`
- One sub-module, `rr_pick`: combinational round-robin priority pick. Inputs are an eligibility vector and a start pointer. Outputs are a one-hot grant, an index, and an any-eligible flag.
- Total RTL target: about 200 lines.

## Test plan
- **Basic:** `NUM_IN=4`, requester 2 sends a 3-beat packet with ctl=0xABC0 → `o_res` carries the beats 1 cycle later with `ctl[1:0]=2`. A loopback returns them on `o_axi[2]` with `ctl[1:0]=0`. `cnt[2]` goes 0→1→0.
- **Round-robin:** all 4 requesters continuously send 1-beat packets → the grant order is 0,1,2,3,0,… with 1 beat per cycle and no bubbles.
- **Credit limit:** `MAX_CREDIT=2`, `o_axi[1].rdy=0`, requester 1 offers 5 packets → exactly 2 are accepted and `cnt[1]` holds at 2. Requester 0 traffic keeps flowing. Releasing `rdy` lets the 3rd packet be granted 1 cycle after the first `eop` returns.
- **Simultaneous events:** requester 0 `sop` is accepted in the same cycle its earlier `eop` returns → `cnt[0]` is unchanged.
- **Error:** `i_res` beat with index 3 while `cnt[3]=0` → `o_err` is set and stays set until `i_rst`.
- **Reset mid-packet:** `i_rst` asserted during `LOCK` → the next cycle shows `o_res.val=0`, `IDLE`, and all counts 0. The requester's next `sop` is granted normally.
